// File: rtl/conv_maxpool_pkg.sv
// Shared definitions for the 2x2 max-pool block: FSM encoding, FP32 field constants,
// and helpers for the sign-magnitude total order used by fp_max.
package conv_maxpool_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
  localparam int unsigned SIGN_BIT     = 31;
  localparam logic [31:0] CANON_NAN    = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == EXP_ALL_ONES) && (v[22:0] != 23'd0);
  endfunction

  // Maps a non-NaN float to an unsigned key whose ordering is the total order,
  // so -0 sorts just below +0 and denormals compare by raw bits.
  function automatic logic [31:0] order_key(input logic [31:0] v);
    return v[SIGN_BIT] ? {1'b0, ~v[30:0]} : {1'b1, v[30:0]};
  endfunction

endpackage

// File: rtl/conv_maxpool_fp.sv
// Combinational FP32 max: NaN operands win (left first), ties keep the left operand.
module fp_max
  import conv_maxpool_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = a;
    if (is_nan(a)) begin
      y = a;
    end else if (is_nan(b)) begin
      y = b;
    end else if (order_key(b) > order_key(a)) begin
      y = b;
    end
  end

endmodule

// File: rtl/conv_maxpool.sv
// Streaming 2x2 stride-2 max-pool over a WxH FP32 map; even rows fold into a half-width
// line buffer, odd rows complete each window and emit one result.
module conv_maxpool
  import conv_maxpool_pkg::*;
#(
  parameter int unsigned W = 4,
  parameter int unsigned H = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned RW = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned LD = W / 2;
  localparam int unsigned LW = (LD > 1) ? $clog2(LD) : 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [31:0]   pair_q, pair_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          overflow_q, overflow_d;
  logic          last_q, last_d;
  logic [31:0]   line_q [LD];

  logic          run, accept, handshake, start_ok, col_last, row_last;
  logic [LW-1:0] half_col;
  logic [31:0]   max_pair, max_win;

  assign run       = (state_q == StRun);
  assign in_ready  = run && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;
  assign start_ok  = start && !run;
  assign col_last  = (col_q == CW'(W - 1));
  assign row_last  = (row_q == RW'(H - 1));
  assign half_col  = LW'(col_q >> 1);

  fp_max u_max_pair (
    .a (pair_q),
    .b (in_data),
    .y (max_pair)
  );

  fp_max u_max_win (
    .a (line_q[half_col]),
    .b (max_pair),
    .y (max_win)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    last_d      = last_q;
    if (start_ok) begin
      state_d     = StRun;
      col_d       = '0;
      row_d       = '0;
      overflow_d  = 1'b0;
      last_d      = 1'b0;
      out_valid_d = 1'b0;
    end else if (run) begin
      if (in_valid && !in_ready) overflow_d = 1'b1;
      if (handshake) out_valid_d = 1'b0;
      if (accept) begin
        if (col_last) begin
          col_d = '0;
          row_d = row_last ? '0 : row_q + 1'b1;
          if (row_last) last_d = 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (!col_q[0]) begin
          pair_d = in_data;
        end else if (row_q[0]) begin
          // A new result overrides the handshake clear above.
          out_valid_d = 1'b1;
          out_data_d  = max_win;
        end
      end
      if (handshake && last_q) begin
        state_d = StDone;
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      last_q      <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !row_q[0] && col_q[0]) line_q[half_col] <= max_pair;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_conv_maxpool.sv
// Self-checking bench for conv_maxpool (W=H=4): directed frame table, randomized frames
// against a value-level reference model, and backpressure / reset sequences.
module tb_conv_maxpool;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, done, overflow;
  logic [31:0] out_data;

  int errors = 0;
  int checks = 0;

  conv_maxpool #(.W(4), .H(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][31:0] din;
    logic [3:0][31:0]  exp;
  } vec_t;

  localparam logic [31:0] ONE_TO_16 [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

  localparam logic [31:0] SPECIALS [8] = '{
    32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
    32'h00000001, 32'h80000001, 32'h7FC00000, 32'hFFC00001};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: decode to a real value and compare numerically.
  function automatic logic ref_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction

  function automatic real ref_val(input logic [31:0] v);
    real m;
    int  e;
    e = int'(v[30:23]);
    m = real'(v[22:0]);
    if (e == 0) m = m * (2.0 ** (-149));
    else        m = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    if (ref_nan(a)) return a;
    if (ref_nan(b)) return b;
    if (ref_val(a) > ref_val(b)) return a;
    if (ref_val(b) > ref_val(a)) return b;
    if (a[31] && !b[31]) return b;  // -0 vs +0
    return a;
  endfunction

  function automatic logic [3:0][31:0] ref_frame(input logic [15:0][31:0] d);
    logic [3:0][31:0] r;
    for (int wr = 0; wr < 2; wr++) begin
      for (int wc = 0; wc < 2; wc++) begin
        int b;
        b = wr * 8 + wc * 2;
        r[wr * 2 + wc] = ref_max(ref_max(ref_max(d[b], d[b + 1]), d[b + 4]), d[b + 5]);
      end
    end
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0][31:0] din, input logic [3:0][31:0] exp,
                           input bit rnd, input string tag);
    logic [31:0] got[$];
    int idx, cyc;
    idx = 0;
    cyc = 0;
    pulse_start();
    while (got.size() < 4 && cyc < 400) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      in_valid = (idx < 16) && in_ready && (!rnd || $urandom_range(0, 2) != 0);
      in_data  = (idx < 16) ? din[idx] : 32'h0;
      #1;
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, " result count"}, 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      chk($sformatf("%s out%0d", tag, i), got[i], exp[i]);
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
  endtask

  vec_t vecs [3];

  initial begin
    // Directed table
    for (int k = 0; k < 16; k++) vecs[0].din[k] = ONE_TO_16[k];
    vecs[0].exp = {32'h41800000, 32'h41600000, 32'h41000000, 32'h40C00000};
    vecs[1].din = '0;
    vecs[1].din[0] = 32'hBF800000;
    vecs[1].din[1] = 32'hC0000000;
    vecs[1].din[4] = 32'h80000000;
    vecs[1].din[5] = 32'hC0800000;
    vecs[1].din[2] = 32'h00000000;
    vecs[1].din[3] = 32'h80000000;
    vecs[1].din[6] = 32'h80000000;
    vecs[1].din[7] = 32'h80000000;
    for (int j = 0; j < 4; j++) begin
      vecs[1].din[8 + j]  = ONE_TO_16[j];
      vecs[1].din[12 + j] = ONE_TO_16[4 + j];
    end
    vecs[1].exp = {32'h41000000, 32'h40C00000, 32'h00000000, 32'h80000000};
    vecs[2] = vecs[0];
    vecs[2].din[8] = 32'h7FC00000;
    vecs[2].exp = {32'h41800000, 32'h7FC00000, 32'h41000000, 32'h40C00000};

    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;

    @(negedge clk) in_valid = 1'b1;
    @(negedge clk) in_valid = 1'b0;
    chk("idle in_valid overflow", 32'(overflow), 32'd0);
    chk("idle in_ready", 32'(in_ready), 32'd0);

    for (int v = 0; v < 3; v++) run_frame(vecs[v].din, vecs[v].exp, 1'b0, $sformatf("vec%0d", v));

    // Randomized frames with random handshakes
    for (int f = 0; f < 8; f++) begin
      logic [15:0][31:0] d;
      for (int k = 0; k < 16; k++) begin
        d[k] = ($urandom_range(0, 3) == 0) ? SPECIALS[$urandom_range(0, 7)] : $urandom;
      end
      run_frame(d, ref_frame(d), 1'b1, $sformatf("rand%0d", f));
    end

    // Backpressure at first output, then overflow
    pulse_start();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = ONE_TO_16[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp out_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold data c%0d", c), out_data, 32'h40C00000);
      chk($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    @(negedge clk) in_valid = 1'b0;
    chk("bp overflow", 32'(overflow), 32'd1);
    chk("bp data after overflow", out_data, 32'h40C00000);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = ONE_TO_16[6];
    @(negedge clk) in_valid = 1'b0;
    chk("bp drained", 32'(out_valid), 32'd0);

    // Reset mid-frame after 7 inputs
    #1 rst = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_data", out_data, 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst overflow", 32'(overflow), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 1'b1;
    run_frame(vecs[0].din, vecs[0].exp, 1'b0, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
